line_raster_engine: RTL and testbench
=====================================

// Module: line_raster_engine
// PURPOSE
//  Parametrised pixel rasteriser between the CPU MMIO command regs and the frame-buffer write arbiter.
//  Accepts one draw command (line or filled rectangle, any octant/endpoint order, multi-bit colour).
//  Emits one pixel write per accepted beat on a valid/ready stream with full backpressure.
// PARAMETERS
//  PIXEL_WIDTH   1024               visible columns; need not be a power of two
//  PIXEL_HEIGHT  768                visible rows
//  X_BITS        `log2(PIXEL_WIDTH)  coordinate width, x
//  Y_BITS        `log2(PIXEL_HEIGHT) coordinate width, y
//  COLOR_BITS    8                  pixel data width
//  ADDR_BITS     X_BITS+Y_BITS      frame-buffer address width
// PORTS
//  clk        in   1           system clock
//  rst        in   1           synchronous, active-high reset
//  cmd_x0     in   X_BITS      start x
//  cmd_y0     in   Y_BITS      start y
//  cmd_x1     in   X_BITS      end x
//  cmd_y1     in   Y_BITS      end y
//  cmd_color  in   COLOR_BITS  draw colour
//  cmd_mode   in   1           0 = line, 1 = filled rectangle
//  cmd_valid  in   1           command offered
//  cmd_ready  out  1           engine idle; cmd accepted on cmd_valid & cmd_ready
//  wr_valid   out  1           pixel write offered to arbiter
//  wr_ready   in   1           arbiter accepts write
//  wr_addr    out  ADDR_BITS   {y, x}
//  wr_data    out  COLOR_BITS  latched cmd_color
//  busy       out  1           high in SETUP/DRAW
//  done       out  1           1-cycle pulse after last pixel accepted
// BEHAVIOUR
//  Reset: FSM -> IDLE; wr_valid=0, done=0, busy=0, cmd_ready=1. In-flight command dropped, no further writes.
//  FSM IDLE -> SETUP on cmd fire: latch x0,y0,x1,y1,color,mode.
//  SETUP (1 cycle): dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1/-1 toward endpoint, err=dx+dy.
//   All arithmetic signed, X_BITS+2 bits (max of X/Y), no overflow.
//  DRAW: current pixel starts at (x0,y0); wr_valid asserted; first write on cycle N+2 after cmd fire at N.
//  Pixel advances only on wr_valid & wr_ready; addr/data held stable while stalled. wr_valid never retracted.
//  Line step (all octants, no endpoint swap): e2=2*err;
//   if e2>=dy { err+=dy; x+=sx }; if e2<=dx { err+=dx; y+=sy } (both tests use pre-update err).
//  Line length: max(dx,-dy)+1 pixels, inclusive of both endpoints; x0==x1 & y0==y1 -> exactly 1 pixel.
//  Rect: raster order, x from min(x0,x1) to max, then y+1, rows min(y)..max(y); (dx+1)*(-dy+1) pixels.
//  Last pixel accepted -> DONE state for 1 cycle: done=1, busy=0, cmd_ready=1 (a new cmd may fire that cycle) -> IDLE/SETUP.
//  cmd_ready=0 in SETUP/DRAW; cmd_valid then ignored. Input ports need only be stable in the fire cycle.
//  Pixel counter width X_BITS+Y_BITS+1; termination on counter, not coordinate compare.
// CONFIGURATION
//  LINE_RASTER_CLIP_EN defined: pixels with x>=PIXEL_WIDTH or y>=PIXEL_HEIGHT are stepped internally
//   (one cycle each, wr_valid=0) but never written; the pixel count still includes them.
//   done still pulses; a fully off-screen command emits zero writes.
//  LINE_RASTER_CLIP_EN undefined: every rasterised pixel is written with addr {y,x}; no range checks.
// TESTING
//  1 Line (0,0)->(3,0), c=8'h5A, wr_ready=1 -> addrs 0,1,2,3 on consecutive cycles, data 5A; done 1 cycle after addr 3.
//  2 Line (3,3)->(0,0) -> pixels (3,3),(2,2),(1,1),(0,0) in that order; no swap.
//  3 Steep line (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3) = addrs 0,1024,2049,3073.
//  4 Rect (2,2)->(1,1), mode=1 -> (1,1),(2,1),(1,2),(2,2); wr_ready low 3 cycles on pixel 2 -> addr held, no dup/skip.
//  5 rst=1 for 1 cycle during pixel 2 of a 10-px line -> next cycle wr_valid=0, cmd_ready=1, no done; new cmd works.
//  6 PIXEL_WIDTH=800, line (798,0)->(801,0): with CLIP_EN -> only 798,799 written, done after 4 steps; without -> 4 writes.

Source files
------------

// File: rtl/line_raster_engine.sv
// Line / filled-rectangle rasteriser: one {y,x} pixel write per accepted valid/ready beat.
// Optional build macro LINE_RASTER_CLIP_EN suppresses writes outside PIXEL_WIDTH x PIXEL_HEIGHT.
module line_raster_engine #(
  parameter int PIXEL_WIDTH  = 1024,
  parameter int PIXEL_HEIGHT = 768,
  parameter int X_BITS       = $clog2(PIXEL_WIDTH),
  parameter int Y_BITS       = $clog2(PIXEL_HEIGHT),
  parameter int COLOR_BITS   = 8,
  parameter int ADDR_BITS    = X_BITS + Y_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_BITS-1:0]     cmd_x0,
  input  logic [Y_BITS-1:0]     cmd_y0,
  input  logic [X_BITS-1:0]     cmd_x1,
  input  logic [Y_BITS-1:0]     cmd_y1,
  input  logic [COLOR_BITS-1:0] cmd_color,
  input  logic                  cmd_mode,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic [COLOR_BITS-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state_o
);

  // Both streams are valid/ready: a beat transfers on a rising edge where valid & ready are both high;
  // once wr_valid rises it stays high with addr/data frozen until that transfer happens.
  localparam int CW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;
  localparam int NW = X_BITS + Y_BITS + 1;
  localparam logic signed [CW-1:0] ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [X_BITS-1:0]       x_q, x_d, xe_q, xe_d, x_lo_q, x_lo_d, x_hi_q, x_hi_d;
  logic [Y_BITS-1:0]       y_q, y_d, ye_q, ye_d;
  logic [COLOR_BITS-1:0]   color_q, color_d;
  logic                    mode_q, mode_d, sx_q, sx_d, sy_q, sy_d;
  logic signed [CW-1:0]    dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic [NW-1:0]           cnt_q, cnt_d;

  logic signed [CW-1:0]    xs, xe, ys, ye, adx, ady, err_n;
  logic signed [CW:0]      e2;
  logic [NW-1:0]           span_line, len_rect;
  logic                    on_screen, cmd_fire, advance;

  assign xs  = $signed({{(CW-X_BITS){1'b0}}, x_q});
  assign xe  = $signed({{(CW-X_BITS){1'b0}}, xe_q});
  assign ys  = $signed({{(CW-Y_BITS){1'b0}}, y_q});
  assign ye  = $signed({{(CW-Y_BITS){1'b0}}, ye_q});
  assign adx = (xe >= xs) ? xe - xs : xs - xe;
  assign ady = (ye >= ys) ? ye - ys : ys - ye;
  assign e2  = {err_q, 1'b0};

  // cnt holds pixels remaining minus one; termination never compares coordinates
  assign span_line = (adx >= ady) ? NW'(adx) : NW'(ady);
  assign len_rect  = NW'(adx + ONE) * NW'(ady + ONE);

`ifdef LINE_RASTER_CLIP_EN
  localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(PIXEL_WIDTH);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(PIXEL_HEIGHT);
  assign on_screen = ({1'b0, x_q} < X_LIM) && ({1'b0, y_q} < Y_LIM);
`else
  assign on_screen = 1'b1;
`endif

  assign cmd_ready   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign busy        = (state_q == S_SETUP) || (state_q == S_DRAW);
  assign done        = (state_q == S_DONE);
  assign wr_valid    = (state_q == S_DRAW) && on_screen;
  // Off-screen pixels step through in a single cycle without a write
  assign advance     = (state_q == S_DRAW) && (on_screen ? wr_ready : 1'b1);
  assign wr_addr     = {y_q, x_q};
  assign wr_data     = color_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    xe_d    = xe_q;
    x_lo_d  = x_lo_q;
    x_hi_d  = x_hi_q;
    y_d     = y_q;
    ye_d    = ye_q;
    color_d = color_q;
    mode_d  = mode_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    err_n   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_fire) begin
          state_d = S_SETUP;
          x_d     = cmd_x0;
          y_d     = cmd_y0;
          xe_d    = cmd_x1;
          ye_d    = cmd_y1;
          color_d = cmd_color;
          mode_d  = cmd_mode;
        end
      end
      S_SETUP: begin
        state_d = S_DRAW;
        dx_d    = adx;
        dy_d    = -ady;
        err_d   = adx - ady;
        sx_d    = (xe_q >= x_q);
        sy_d    = (ye_q >= y_q);
        cnt_d   = mode_q ? len_rect - NW'(1) : span_line;
        x_lo_d  = (x_q <= xe_q) ? x_q : xe_q;
        x_hi_d  = (x_q <= xe_q) ? xe_q : x_q;
        if (mode_q) begin
          x_d = (x_q <= xe_q) ? x_q : xe_q;
          y_d = (y_q <= ye_q) ? y_q : ye_q;
        end
      end
      S_DRAW: begin
        if (advance) begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - NW'(1);
            if (mode_q) begin
              if (x_q == x_hi_q) begin
                x_d = x_lo_q;
                y_d = y_q + 1'b1;
              end else begin
                x_d = x_q + 1'b1;
              end
            end else begin
              // Both tests use the pre-step error term
              if (e2 >= dy_q) begin
                err_n = err_n + dy_q;
                x_d   = sx_q ? x_q + 1'b1 : x_q - 1'b1;
              end
              if (e2 <= dx_q) begin
                err_n = err_n + dx_q;
                y_d   = sy_q ? y_q + 1'b1 : y_q - 1'b1;
              end
              err_d = err_n;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      xe_q    <= '0;
      x_lo_q  <= '0;
      x_hi_q  <= '0;
      y_q     <= '0;
      ye_q    <= '0;
      color_q <= '0;
      mode_q  <= 1'b0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      xe_q    <= xe_d;
      x_lo_q  <= x_lo_d;
      x_hi_q  <= x_hi_d;
      y_q     <= y_d;
      ye_q    <= ye_d;
      color_q <= color_d;
      mode_q  <= mode_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Bench for line_raster_engine at PIXEL_WIDTH=800: hand sequences for timing/stall/reset/clip,
// then a table of commands checked pixel-by-pixel against a Bresenham/raster reference queue.
module tb_line_raster_engine;
  localparam int PW = 800;
  localparam int PH = 768;
`ifdef LINE_RASTER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct { int x0; int y0; int x1; int y1; int c; int m; int n; } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [9:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [7:0]  cmd_color = '0;
  logic        cmd_mode = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic        wr_valid, wr_ready = 1'b1, busy, done;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  dbg_state;

  line_raster_engine #(.PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .COLOR_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_mode(cmd_mode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int wr_cnt = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0, fire_cyc = 0;
  int ready_mode = 0, stall_at = 0, stall_left = 0;
  logic        stall_prev = 1'b0;
  logic [19:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  logic [27:0] got_px, want_px;
  logic [27:0] exp_q[$];
  vec_t        tbl[12];

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: wr_ready = 1'b1;
      1: wr_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (wr_cnt == stall_at && stall_left > 0) begin
          wr_ready = 1'b0;
          stall_left--;
        end else begin
          wr_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic issue(input vec_t v);
    int t = 0;
    @(posedge clk); #1;
    cmd_x0 = 10'(v.x0); cmd_y0 = 10'(v.y0);
    cmd_x1 = 10'(v.x1); cmd_y1 = 10'(v.y1);
    cmd_color = 8'(v.c); cmd_mode = v.m[0]; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("cmd_accept", cmd_ready, 1);
    fire_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_x0 = 10'($urandom_range(0, 1023)); cmd_y0 = 10'($urandom_range(0, 1023));
    cmd_x1 = 10'($urandom_range(0, 1023)); cmd_y1 = 10'($urandom_range(0, 1023));
    cmd_color = 8'($urandom_range(0, 255)); cmd_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int limit);
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < limit) begin
      @(negedge clk);
      t++;
      if (done) begin
        seen = 1'b1;
        check_eq("done_busy_low", busy, 0);
        check_eq("done_cmd_ready", cmd_ready, 1);
      end
    end
    check_eq("done_seen", seen, 1);
    @(negedge clk);
    check_eq("done_pulse_width", done, 0);
  endtask

  // ---------------- reference model ----------------
  task automatic push_xy(input int x, input int y, input int c);
    if (!CLIP || (x < PW && y < PH)) exp_q.push_back({10'(y), 10'(x), 8'(c)});
  endtask

  task automatic model(input vec_t v);
    int x, y, dx, dy, sx, sy, err, e2, n;
    if (v.m == 0) begin
      dx  = (v.x1 > v.x0) ? v.x1 - v.x0 : v.x0 - v.x1;
      dy  = (v.y1 > v.y0) ? v.y0 - v.y1 : v.y1 - v.y0;
      sx  = (v.x0 < v.x1) ? 1 : -1;
      sy  = (v.y0 < v.y1) ? 1 : -1;
      err = dx + dy;
      x = v.x0; y = v.y0;
      n = ((dx > -dy) ? dx : -dy) + 1;
      for (int i = 0; i < n; i++) begin
        push_xy(x, y, v.c);
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end else begin
      for (int yy = (v.y0 < v.y1 ? v.y0 : v.y1); yy <= (v.y0 < v.y1 ? v.y1 : v.y0); yy++)
        for (int xx = (v.x0 < v.x1 ? v.x0 : v.x1); xx <= (v.x0 < v.x1 ? v.x1 : v.x0); xx++)
          push_xy(xx, yy, v.c);
    end
  endtask

  task automatic run_cmd(input vec_t v, input bit use_model);
    if (use_model) model(v);
    wr_cnt = 0;
    issue(v);
    wait_done(5000);
    check_eq("write_count", wr_cnt, v.n);
    check_eq("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", wr_valid, 1);
        check_eq("hold_addr", wr_addr, prev_addr);
        check_eq("hold_data", wr_data, prev_data);
      end
      if (wr_valid && wr_ready) begin
        if (wr_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        wr_cnt++;
        got_px  = {wr_addr, wr_data};
        want_px = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check_eq("pixel", got_px, want_px);
      end
      stall_prev = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t v, va;
    int t, d0;
    tbl[0]  = '{10, 20, 2, 17, 'h3C, 0, 9};
    tbl[1]  = '{0, 9, 4, 0, 'h81, 0, 10};
    tbl[2]  = '{0, 0, 3, 2, 'h42, 1, 12};
    tbl[3]  = '{100, 50, 95, 70, 'hC3, 0, 21};
    tbl[4]  = '{5, 5, 5, 5, 'h01, 0, 1};
    tbl[5]  = '{7, 7, 7, 7, 'hFE, 1, 1};
    tbl[6]  = '{0, 0, 799, 767, 'h77, 0, 800};
    tbl[7]  = '{799, 767, 798, 766, 'h99, 1, 4};
    tbl[8]  = '{798, 0, 801, 0, 'hAA, 0, CLIP ? 2 : 4};
    tbl[9]  = '{900, 0, 901, 1, 'hBB, 1, CLIP ? 0 : 4};
    tbl[10] = '{30, 40, 33, 12, 'h5F, 0, 29};
    tbl[11] = '{6, 3, 2, 5, 'hE1, 1, 15};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_wr_valid", wr_valid, 0);
    check_eq("reset_cmd_ready", cmd_ready, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_state", dbg_state, 0);

    // Horizontal line: latency N+2, consecutive writes, done right after the last one
    for (int x = 0; x < 4; x++) push_xy(x, 0, 'h5A);
    v = '{0, 0, 3, 0, 'h5A, 0, 4};
    run_cmd(v, 1'b0);
    check_eq("t1_first_latency", first_cyc - fire_cyc, 2);
    check_eq("t1_last_latency", last_cyc - fire_cyc, 5);
    check_eq("t1_done_after_last", done_cyc - last_cyc, 1);

    // Reversed diagonal, steep line
    push_xy(3, 3, 'h12); push_xy(2, 2, 'h12); push_xy(1, 1, 'h12); push_xy(0, 0, 'h12);
    v = '{3, 3, 0, 0, 'h12, 0, 4};
    run_cmd(v, 1'b0);
    exp_q.push_back({20'd0, 8'h34}); exp_q.push_back({20'd1024, 8'h34});
    exp_q.push_back({20'd2049, 8'h34}); exp_q.push_back({20'd3073, 8'h34});
    v = '{0, 0, 1, 3, 'h34, 0, 4};
    run_cmd(v, 1'b0);

    // Rectangle with 3-cycle stall on its second pixel
    exp_q.push_back({20'd1025, 8'h6B}); exp_q.push_back({20'd1026, 8'h6B});
    exp_q.push_back({20'd2049, 8'h6B}); exp_q.push_back({20'd2050, 8'h6B});
    stall_at = 1; stall_left = 3; ready_mode = 2;
    v = '{2, 2, 1, 1, 'h6B, 1, 4};
    run_cmd(v, 1'b0);
    check_eq("t4_stall_span", last_cyc - first_cyc, 6);
    ready_mode = 0;

    // Reset while pixel 2 of a 10-pixel line is stalled
    for (int x = 0; x < 10; x++) push_xy(x, 5, 'h33);
    wr_cnt = 0; stall_at = 1; stall_left = 1000; ready_mode = 2;
    v = '{0, 5, 9, 5, 'h33, 0, 10};
    issue(v);
    t = 0;
    while (wr_cnt < 1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("t5_reached_pixel2", wr_cnt, 1);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_wr_valid", wr_valid, 0);
    check_eq("t5_cmd_ready", cmd_ready, 1);
    check_eq("t5_busy", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("t5_no_done", done_cnt, d0);
    check_eq("t5_wr_count", wr_cnt, 1);
    exp_q.delete();
    ready_mode = 0; stall_left = 0;
    for (int x = 0; x < 4; x++) push_xy(x, 0, 'h5A);
    v = '{0, 0, 3, 0, 'h5A, 0, 4};
    run_cmd(v, 1'b0);

    // Right-edge line: steps through all 4 positions either way
    for (int x = 798; x < 802; x++) push_xy(x, 0, 'hC7);
    v = '{798, 0, 801, 0, 'hC7, 0, CLIP ? 2 : 4};
    run_cmd(v, 1'b0);
    check_eq("t6_done_timing", done_cyc - fire_cyc, 6);

    // Second command held during DRAW fires in the DONE cycle of the first
    va = '{10, 10, 13, 12, 'h11, 0, 4};
    v  = '{20, 30, 21, 31, 'h22, 1, 4};
    model(va); model(v);
    wr_cnt = 0;
    issue(va);
    issue(v);
    check_eq("b2b_fire_in_done", fire_cyc, done_cyc);
    wait_done(1000);
    check_eq("b2b_write_count", wr_cnt, 8);
    check_eq("b2b_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    // Table sweep, alternating full-rate and random backpressure
    for (int i = 0; i < 12; i++) begin
      ready_mode = i % 2;
      run_cmd(tbl[i], 1'b1);
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
